// File: rtl/irq_timer_ctrl_if.sv
// Single-beat request/ack register port for irq_timer_ctrl.
// The master drives the request; the slave answers with ack, read data and error.
interface irq_timer_ctrl_if;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/irq_timer_ctrl.sv
// Machine-level interrupt source: prescaled 64-bit mtime/mtimecmp timer, MSIP
// software interrupt and a synchronised external interrupt, with a register port.
module irq_timer_ctrl #(
  parameter int unsigned PRESCALER   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  irq_timer_ctrl_if.slave  bus,
  input  logic             ext_irq_i,
  output logic [2:0]       irq_o
);

  localparam int unsigned     CNT_W   = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALER - 1);

  logic [63:0]            mtime;
  logic [63:0]            mtimecmp;
  logic                   msip;
  logic [CNT_W-1:0]       cnt;
  logic                   timer_irq;
  logic                   sw_irq;
  logic [SYNC_STAGES-1:0] sync;

  logic        access;
  logic        addr_ok;
  logic        wr;
  logic        tick;
  logic [31:0] rd_val;

  // A request is only sampled while no ack is outstanding.
  assign access  = bus.req && !bus.ack;
  assign addr_ok = (bus.addr[1:0] == 2'b00) && (bus.addr <= 5'h10);
  assign wr      = access && bus.we && addr_ok;
  assign tick    = (cnt == CNT_MAX);

  always_comb begin
    rd_val = '0;
    case (bus.addr[4:2])
      3'd0:    rd_val = mtime[31:0];
      3'd1:    rd_val = mtime[63:32];
      3'd2:    rd_val = mtimecmp[31:0];
      3'd3:    rd_val = mtimecmp[63:32];
      3'd4:    rd_val = {31'b0, msip};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      msip      <= 1'b0;
      cnt       <= '0;
      timer_irq <= 1'b0;
      sw_irq    <= 1'b0;
      sync      <= '0;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ack   <= access;
      bus.err   <= access && !addr_ok;
      bus.rdata <= (access && addr_ok) ? rd_val : '0;

      // An mtime write replaces that cycle's increment and restarts the prescaler.
      if (wr && (bus.addr[4:2] == 3'd0)) begin
        mtime[31:0] <= bus.wdata;
        cnt         <= '0;
      end else if (wr && (bus.addr[4:2] == 3'd1)) begin
        mtime[63:32] <= bus.wdata;
        cnt          <= '0;
      end else if (tick) begin
        mtime <= mtime + 64'd1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (wr && (bus.addr[4:2] == 3'd2)) mtimecmp[31:0]  <= bus.wdata;
      if (wr && (bus.addr[4:2] == 3'd3)) mtimecmp[63:32] <= bus.wdata;
      if (wr && (bus.addr[4:2] == 3'd4)) msip            <= bus.wdata[0];

      timer_irq <= (mtime >= mtimecmp);
      sw_irq    <= msip;
      sync      <= {sync[SYNC_STAGES-2:0], ext_irq_i};
    end
  end

  assign irq_o = {sync[SYNC_STAGES-1], sw_irq, timer_irq};

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Scoreboard bench for irq_timer_ctrl: stimulus pushes expected responses from an
// arithmetic model of mtime (base + elapsed/PRESCALER); a monitor checks each ack.
module tb_irq_timer_ctrl;
  localparam int unsigned P = 4;
  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ext = 1'b0;
  logic [2:0] irq;

  irq_timer_ctrl_if bus();

  irq_timer_ctrl #(.PRESCALER(P), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ext_irq_i(ext), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [2:0]  irq;
  } exp_t;
  exp_t q[$];

  // Model: mtime equals base at edge count nw and gains one per P edges after it.
  logic [63:0] base;
  logic [63:0] cmp;
  int unsigned nw;
  logic        msip;

  function automatic logic [63:0] mtime_at(input int unsigned n);
    return base + 64'((n - nw) / P);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    base = '0;
    cmp  = '1;
    msip = 1'b0;
    nw   = cyc;
  endtask

  task automatic access(input logic w, input logic [4:0] a, input logic [31:0] d);
    exp_t        e;
    int unsigned n;
    logic [63:0] mt;
    logic        ok;
    @(negedge clk);
    n  = cyc;
    mt = mtime_at(n);
    ok = (a[1:0] == 2'b00) && (a <= 5'h10);
    e.err = !ok;
    e.irq = {1'b0, msip, (mt >= cmp)};
    e.rdata = '0;
    if (ok) begin
      case (a[4:2])
        3'd0:    e.rdata = mt[31:0];
        3'd1:    e.rdata = mt[63:32];
        3'd2:    e.rdata = cmp[31:0];
        3'd3:    e.rdata = cmp[63:32];
        default: e.rdata = {31'b0, msip};
      endcase
    end
    q.push_back(e);
    if (w && ok) begin
      case (a[4:2])
        3'd0:    begin base = {mt[63:32], d}; nw = n + 1; end
        3'd1:    begin base = {d, mt[31:0]}; nw = n + 1; end
        3'd2:    cmp[31:0]  = d;
        3'd3:    cmp[63:32] = d;
        default: msip = d[0];
      endcase
    end
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.ack) begin
      if (q.size() == 0) begin
        check("unexpected_ack", 64'(bus.ack), 64'd0);
      end else begin
        e = q.pop_front();
        check("rdata", 64'(bus.rdata), 64'(e.rdata));
        check("err",   64'(bus.err),   64'(e.err));
        check("irq",   64'(irq),       64'(e.irq));
      end
    end else begin
      check("rdata_idle", 64'(bus.rdata), 64'd0);
    end
  end

  initial begin
    logic [63:0] cur;
    bit          seen;
    logic [4:0]  a;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("irq_after_reset", 64'(irq), 64'd0);

    access(1'b0, 5'h08, '0);
    access(1'b0, 5'h0C, '0);

    access(1'b1, 5'h00, '0);
    repeat (40) @(negedge clk);
    access(1'b0, 5'h00, '0);

    access(1'b1, 5'h00, 32'hFFFF_FFFF);
    access(1'b1, 5'h04, '0);
    access(1'b0, 5'h00, '0);
    repeat (8) @(negedge clk);
    access(1'b0, 5'h04, '0);
    access(1'b0, 5'h00, '0);

    access(1'b1, 5'h0C, '0);
    cur = mtime_at(cyc + 1);
    access(1'b1, 5'h08, cur[31:0] + 32'd5);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = irq[0];
    end
    check("timer_irq_rise", 64'(seen), 64'd1);
    access(1'b1, 5'h0C, 32'd1);
    @(negedge clk);
    check("timer_irq_drop", 64'(irq[0]), 64'd0);

    access(1'b1, 5'h10, 32'hFFFF_FFFF);
    access(1'b0, 5'h10, '0);
    check("sw_irq_set", 64'(irq[1]), 64'd1);
    access(1'b1, 5'h10, '0);
    @(negedge clk);
    check("sw_irq_clr", 64'(irq[1]), 64'd0);

    @(negedge clk);
    ext = 1'b1;
    check("ext_n", 64'(irq[2]), 64'd0);
    @(negedge clk);
    ext = 1'b0;
    check("ext_n1", 64'(irq[2]), 64'd0);
    @(negedge clk);
    check("ext_n2", 64'(irq[2]), 64'd1);
    @(negedge clk);
    check("ext_n3", 64'(irq[2]), 64'd0);

    access(1'b1, 5'h14, 32'hFFFF_FFFF);
    access(1'b1, 5'h02, 32'hFFFF_FFFF);
    access(1'b0, 5'h10, '0);
    access(1'b0, 5'h08, '0);

    @(negedge clk);
    rst = 1'b1;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 5'h08; bus.wdata = '0;
    @(negedge clk);
    rst = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0;
    model_reset();
    check("ack_suppressed", 64'(bus.ack), 64'd0);
    check("irq_mid_reset", 64'(irq), 64'd0);
    access(1'b0, 5'h08, '0);
    access(1'b0, 5'h00, '0);

    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 3) != 0) a = 5'($urandom_range(0, 4) * 4);
      else a = 5'($urandom_range(0, 31));
      access(1'($urandom_range(0, 1)), a, $urandom);
    end

    repeat (3) @(negedge clk);
    check("pending_acks", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
